// File: rtl/sl_receiver.sv
// sl_receiver: two-wire SL serial word receiver with odd parity,
// length and inter-bit gap checking, sticky status and config readback.
module sl_receiver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sl0,
    input  logic        sl1,
    input  logic [9:0]  wr_config_w,
    input  logic        wr_config_enable,
    output logic [9:0]  r_config_w,
    input  logic        rd_data,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        word_in_process,
    output logic [5:0]  bit_count,
    output logic [3:0]  status,
    output logic        status_changed
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BIT  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]  sync1_q, sync2_q, line;
    logic [1:0]  state_q, state_d;
    logic        bitval_q, bitval_d;
    logic [32:0] shreg_q, shreg_d;
    logic [5:0]  bcnt_q, bcnt_d;
    logic        wip_q, wip_d;
    logic        dv_q, dv_d;
    logic [31:0] dout_q, dout_d;
    logic [3:0]  status_q, status_d;
    logic [5:0]  len_q, len_d;
    logic [2:0]  fm_q, fm_d;
    logic [11:0] gap_q, gap_d;
    logic [11:0] gap_lim;
    logic [2:0]  fm_sh;
    logic [5:0]  prev_q;
    logic        sc_q;
    logic        good;
    logic        cfg_ok;
    logic        unused_rsvd;

    assign unused_rsvd = wr_config_w[6];
    assign line        = sync2_q;
    assign fm_sh       = (fm_q > 3'd5) ? 3'd5 : fm_q;
    assign gap_lim     = 12'd64 << fm_sh;
    assign cfg_ok      = (wr_config_w[5:0] >= 6'd8) &&
                         (wr_config_w[5:0] <= 6'd32);

    always_comb begin
        state_d  = state_q;
        bitval_d = bitval_q;
        shreg_d  = shreg_q;
        bcnt_d   = bcnt_q;
        wip_d    = wip_q;
        dv_d     = dv_q;
        dout_d   = dout_q;
        status_d = status_q;
        len_d    = len_q;
        fm_d     = fm_q;
        gap_d    = '0;
        good     = 1'b0;
        if (rd_data) dv_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (line == 2'b00) begin
                    state_d = ST_STOP;
                    wip_d   = 1'b0;
                    if (wip_q) begin
                        if ({1'b0, bcnt_q} != ({1'b0, len_q} + 7'd1))
                            status_d[0] = 1'b1;
                        else if (!(^shreg_q))
                            status_d[1] = 1'b1;
                        else
                            good = 1'b1;
                    end
                end else if (line != 2'b11) begin
                    state_d  = ST_BIT;
                    bitval_d = ~line[1];
                end else if (wip_q) begin
                    if (gap_q == gap_lim - 12'd1) begin
                        status_d[0] = 1'b1;
                        wip_d       = 1'b0;
                    end else begin
                        gap_d = gap_q + 12'd1;
                    end
                end
            end
            ST_BIT: begin
                if (line == 2'b11) begin
                    state_d = ST_IDLE;
                    if (wip_q) begin
                        shreg_d = {shreg_q[31:0], bitval_q};
                        bcnt_d  = (bcnt_q == 6'd63) ? 6'd63 : bcnt_q + 6'd1;
                    end else begin
                        wip_d   = 1'b1;
                        shreg_d = {32'd0, bitval_q};
                        bcnt_d  = 6'd1;
                    end
                end else if (line != {~bitval_q, bitval_q}) begin
                    // Illegal transition: drop the word, resync on idle.
                    status_d[2] = 1'b1;
                    wip_d       = 1'b0;
                    state_d     = ST_STOP;
                end
            end
            ST_STOP: begin
                if (line == 2'b11) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (good && !wr_config_enable) begin
            if (!dv_q || rd_data) begin
                dout_d = shreg_q[32:1];
                dv_d   = 1'b1;
            end else begin
                status_d[3] = 1'b1;
            end
        end
        if (wr_config_enable) begin
            status_d = '0;
            wip_d    = 1'b0;
            gap_d    = '0;
            state_d  = (line == 2'b11) ? ST_IDLE : ST_STOP;
            if (cfg_ok) begin
                len_d = wr_config_w[5:0];
                fm_d  = wr_config_w[9:7];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            state_q  <= ST_IDLE;
            bitval_q <= 1'b0;
            shreg_q  <= '0;
            bcnt_q   <= '0;
            wip_q    <= 1'b0;
            dv_q     <= 1'b0;
            dout_q   <= '0;
            status_q <= '0;
            len_q    <= 6'd32;
            fm_q     <= '0;
            gap_q    <= '0;
            prev_q   <= '0;
            sc_q     <= 1'b0;
        end else begin
            sync1_q  <= {sl1, sl0};
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            bitval_q <= bitval_d;
            shreg_q  <= shreg_d;
            bcnt_q   <= bcnt_d;
            wip_q    <= wip_d;
            dv_q     <= dv_d;
            dout_q   <= dout_d;
            status_q <= status_d;
            len_q    <= len_d;
            fm_q     <= fm_d;
            gap_q    <= gap_d;
            prev_q   <= {dv_q, wip_q, status_q};
            sc_q     <= ({dv_q, wip_q, status_q} != prev_q);
        end
    end

    assign r_config_w      = {fm_q, 1'b0, len_q};
    assign data_out        = dout_q;
    assign data_valid      = dv_q;
    assign word_in_process = wip_q;
    assign bit_count       = bcnt_q;
    assign status          = status_q;
    assign status_changed  = sc_q;

endmodule

// File: tb/tb_sl_receiver.sv
// tb_sl_receiver: directed table, corner sequences and randomized
// words checked against a transaction-level receiver model.
module tb_sl_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sl0 = 1'b1;
    logic        sl1 = 1'b1;
    logic [9:0]  wr_config_w = '0;
    logic        wr_config_enable = 1'b0;
    logic [9:0]  r_config_w;
    logic        rd_data = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic        word_in_process;
    logic [5:0]  bit_count;
    logic [3:0]  status;
    logic        status_changed;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sl_receiver dut (
        .clk(clk), .rst_n(rst_n), .sl0(sl0), .sl1(sl1),
        .wr_config_w(wr_config_w), .wr_config_enable(wr_config_enable),
        .r_config_w(r_config_w), .rd_data(rd_data), .data_out(data_out),
        .data_valid(data_valid), .word_in_process(word_in_process),
        .bit_count(bit_count), .status(status),
        .status_changed(status_changed)
    );

    typedef struct {
        int          fm;
        int          len;
        logic [69:0] bits;
        int          n;
        logic [3:0]  st;
        logic        dv;
        logic [31:0] dout;
        int          bc;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] l, input int c);
        {sl1, sl0} = l;
        repeat (c) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int h, input int g);
        drive(v ? 2'b01 : 2'b10, h);
        drive(2'b11, g);
    endtask

    task automatic send_word(input logic [69:0] b, input int n,
                             input int h, input int g);
        for (int i = n - 1; i >= 0; i--) send_bit(b[i], h, g);
        drive(2'b00, 3);
        drive(2'b11, 4);
    endtask

    task automatic wcfg_raw(input logic [9:0] w);
        wr_config_w = w;
        wr_config_enable = 1'b1;
        @(negedge clk);
        wr_config_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic wcfg(input int fm, input int len);
        wcfg_raw({3'(fm), 1'b0, 6'(len)});
    endtask

    task automatic rd();
        rd_data = 1'b1;
        @(negedge clk);
        rd_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg"}, 32'(r_config_w), 32'h020);
        chk({tag, "_dout"}, data_out, 32'h0);
        chk({tag, "_dv"}, 32'(data_valid), 32'h0);
        chk({tag, "_wip"}, 32'(word_in_process), 32'h0);
        chk({tag, "_bc"}, 32'(bit_count), 32'h0);
        chk({tag, "_st"}, 32'(status), 32'h0);
        chk({tag, "_sc"}, 32'(status_changed), 32'h0);
    endtask

    logic        edv;
    logic [31:0] edout;
    logic [3:0]  est;
    logic [69:0] rb;
    logic [69:0] msk;
    int          rlen, rfm, rn, kind;

    initial begin
        tbl[0] = '{0, 8, 70'h14B, 9, 4'b0000, 1'b1, 32'hA5, 9};
        tbl[1] = '{1, 16, 70'h2469, 17, 4'b0010, 1'b0, 32'hA5, 17};
        tbl[2] = '{2, 12, 70'h155, 10, 4'b0001, 1'b0, 32'hA5, 10};
        tbl[3] = '{0, 32, 70'h1BD5B7DDF, 33, 4'b0000, 1'b1,
                   32'hDEADBEEF, 33};
        tbl[4] = '{5, 8, '1, 70, 4'b0001, 1'b0, 32'hDEADBEEF, 63};

        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        // Stop latency and status_changed timing
        wcfg(0, 8);
        rd();
        for (int i = 8; i >= 0; i--) send_bit(tbl[0].bits[i], 2, 2);
        {sl1, sl0} = 2'b00;
        @(negedge clk);
        chk("lat_e1_dv", 32'(data_valid), 32'h0);
        @(negedge clk);
        chk("lat_e2_dv", 32'(data_valid), 32'h0);
        @(negedge clk);
        chk("lat_e3_dv", 32'(data_valid), 32'h1);
        chk("lat_e3_dout", data_out, 32'hA5);
        @(negedge clk);
        chk("lat_sc_pulse", 32'(status_changed), 32'h1);
        @(negedge clk);
        chk("lat_sc_end", 32'(status_changed), 32'h0);
        drive(2'b11, 4);

        for (int i = 0; i < 5; i++) begin
            wcfg(tbl[i].fm, tbl[i].len);
            chk($sformatf("tbl%0d_cfg", i), 32'(r_config_w),
                32'({3'(tbl[i].fm), 1'b0, 6'(tbl[i].len)}));
            rd();
            send_word(tbl[i].bits, tbl[i].n, 2, 2);
            chk($sformatf("tbl%0d_st", i), 32'(status), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_dv", i), 32'(data_valid), 32'(tbl[i].dv));
            chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].dout);
            chk($sformatf("tbl%0d_bc", i), 32'(bit_count), 32'(tbl[i].bc));
            chk($sformatf("tbl%0d_wip", i), 32'(word_in_process), 32'h0);
        end

        // Gap timeout with freq_mode 0
        wcfg(0, 12);
        for (int i = 0; i < 3; i++) send_bit(i[0], 2, 2);
        drive(2'b11, 28);
        chk("gap_wip_hold", 32'(word_in_process), 32'h1);
        chk("gap_st_hold", 32'(status), 32'h0);
        drive(2'b11, 50);
        chk("gap_st", 32'(status), 32'h1);
        chk("gap_wip", 32'(word_in_process), 32'h0);

        // Overrun
        wcfg(0, 8);
        rd();
        send_word(70'h79, 9, 2, 2);
        send_word(70'h103, 9, 2, 2);
        chk("ovr_st", 32'(status), 32'h8);
        chk("ovr_dout", data_out, 32'h3C);
        chk("ovr_dv", 32'(data_valid), 32'h1);

        // Direct 01 -> 10 transition
        wcfg(0, 8);
        drive(2'b01, 3);
        drive(2'b10, 3);
        drive(2'b11, 4);
        chk("lvl_st", 32'(status), 32'h4);
        chk("lvl_wip", 32'(word_in_process), 32'h0);

        // Out-of-range length and reserved bit readback
        wcfg(3, 40);
        chk("badlen_cfg", 32'(r_config_w), 32'h008);
        chk("badlen_st", 32'(status), 32'h0);
        wcfg_raw(10'h2D0);
        chk("rsvd_cfg", 32'(r_config_w), 32'h290);

        edv = data_valid;
        edout = data_out;
        for (int it = 0; it < 40; it++) begin
            rlen = (it < 12) ? 32 : int'($urandom_range(8, 32));
            rfm  = (it < 12) ? it % 6 : int'($urandom_range(0, 7));
            kind = (it < 12) ? 0 : int'($urandom_range(0, 9));
            rn   = rlen + 1;
            if (kind == 8) rn = rlen;
            if (kind == 9) rn = rlen + 2;
            rb = 70'({$urandom(), $urandom(), $urandom()});
            for (int j = rn; j < 70; j++) rb[j] = 1'b0;
            if (^rb == 1'b0) rb[0] = ~rb[0];
            if (kind == 7) rb[0] = ~rb[0];
            wcfg(rfm, rlen);
            est = '0;
            if (it < 12 || $urandom_range(0, 3) != 0) begin
                rd();
                edv = 1'b0;
            end
            send_word(rb, rn, int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 3)));
            msk = (70'd1 << rlen) - 70'd1;
            if (rn != rlen + 1) est[0] = 1'b1;
            else if (^rb == 1'b0) est[1] = 1'b1;
            else if (edv) est[3] = 1'b1;
            else begin
                edout = 32'((rb >> 1) & msk);
                edv = 1'b1;
            end
            chk($sformatf("rnd%0d_cfg", it), 32'(r_config_w),
                32'({3'(rfm), 1'b0, 6'(rlen)}));
            chk($sformatf("rnd%0d_st", it), 32'(status), 32'(est));
            chk($sformatf("rnd%0d_dv", it), 32'(data_valid), 32'(edv));
            chk($sformatf("rnd%0d_dout", it), data_out, edout);
            chk($sformatf("rnd%0d_bc", it), 32'(bit_count),
                32'((rn > 63) ? 63 : rn));
        end

        // Reset in the middle of a word
        wcfg(0, 8);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 2, 2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rstmid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(i[0], 2, 2);
        drive(2'b00, 3);
        drive(2'b11, 4);
        chk("rstmid_after_st", 32'(status), 32'h1);
        chk("rstmid_after_bc", 32'(bit_count), 32'h4);
        chk("rstmid_after_dv", 32'(data_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
